// File: rtl/lpc_pkg.sv
// Shared LPC constants, FSM encoding and arithmetic helpers used by the
// synthesis datapath and the encoder-side blocks.
package lpc_pkg;

  localparam int CW        = 16;
  localparam int DW        = 16;
  localparam int AW        = 36;
  localparam int LPC_ORDER = 10;
  localparam int Q_FRAC    = 12;
  localparam int NSHIFT    = 3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXC  = 2'd1,
    ST_MAC  = 2'd2,
    ST_SAT  = 2'd3
  } state_e;

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-Q_FRAC-1:0] t);
    logic signed [DW-1:0] r;
    if (t > 24'sd32767) begin
      r = 16'sh7FFF;
    end else if (t < -24'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = t[DW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/lpc_excite.sv
// Excitation source: pitch pulse train when voiced, attenuated LFSR noise
// otherwise. e_o is registered on the accepting strobe and valid during EXC.
module lpc_excite
  import lpc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_i,
  input  logic                 voiced_i,
  input  logic [15:0]          period_i,
  input  logic signed [DW-1:0] gain_i,
  output logic signed [DW-1:0] e_o
);

  logic [15:0]          lfsr_q;
  logic [15:0]          cnt_q;
  logic                 vprev_q;
  logic signed [DW-1:0] e_q;
  logic [15:0]          cnt_s;
  logic [15:0]          cnt_d;
  logic signed [DW-1:0] e_d;

  // Excitation value and next period count for the sample being accepted
  always_comb begin
    if (voiced_i && !vprev_q) begin
      cnt_s = 16'd0;
    end else begin
      cnt_s = cnt_q;
    end
    if (voiced_i && (period_i >= 16'd2)) begin
      if (cnt_s == 16'd0) begin
        e_d = gain_i;
      end else begin
        e_d = 16'sd0;
      end
    end else begin
      e_d = $signed(lfsr_q) >>> NSHIFT;
    end
    if (period_i < 16'd2) begin
      cnt_d = 16'd0;
    end else if (cnt_s >= (period_i - 16'd1)) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_s + 16'd1;
    end
  end

  // Noise, pitch and excitation state advance once per accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= 16'd0;
      vprev_q <= 1'b0;
      e_q     <= 16'sd0;
    end else if (step_i) begin
      lfsr_q  <= lfsr_next(lfsr_q);
      cnt_q   <= cnt_d;
      vprev_q <= voiced_i;
      e_q     <= e_d;
    end
  end

  assign e_o = e_q;

endmodule

// File: rtl/lpc_synth.sv
// LPC synthesis filter: 10th-order all-pole IIR driven by lpc_excite,
// one shared MAC per sample, saturating 16-bit output.
module lpc_synth
  import lpc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 v,
  input  logic                 frame_v,
  input  logic signed [CW-1:0] A0,
  input  logic signed [CW-1:0] A1,
  input  logic signed [CW-1:0] A2,
  input  logic signed [CW-1:0] A3,
  input  logic signed [CW-1:0] A4,
  input  logic signed [CW-1:0] A5,
  input  logic signed [CW-1:0] A6,
  input  logic signed [CW-1:0] A7,
  input  logic signed [CW-1:0] A8,
  input  logic signed [CW-1:0] A9,
  input  logic signed [CW-1:0] A10,
  input  logic                 voiced,
  input  logic [15:0]          freq_count,
  input  logic signed [DW-1:0] gain,
  output logic signed [DW-1:0] y,
  output logic                 vout,
  output logic                 busy,
  output logic                 overrun
);

  state_e               state_q, state_d;
  logic signed [CW-1:0] a_in_s  [1:LPC_ORDER];
  logic signed [CW-1:0] sel_a_s [1:LPC_ORDER];
  logic signed [CW-1:0] st_a_q  [1:LPC_ORDER];
  logic signed [CW-1:0] act_a_q [1:LPC_ORDER];
  logic signed [DW-1:0] hist_q  [1:LPC_ORDER];
  logic                 st_voiced_q, sel_voiced_s;
  logic [15:0]          st_fc_q, sel_fc_s;
  logic signed [DW-1:0] st_gain_q, sel_gain_s;
  logic signed [AW-1:0] acc_q;
  logic [3:0]           k_q;
  logic signed [DW-1:0] y_q;
  logic                 vout_q, overrun_q;
  logic                 busy_s, accept_s;
  logic signed [DW-1:0] e_s;
  logic signed [2*CW-1:0] coef_ext_s, hist_ext_s, prod_s;
  logic signed [DW-1:0] sat_s;
  logic                 a0_unused_s;

  assign a0_unused_s = ^A0;
  assign a_in_s[1] = A1;  assign a_in_s[2] = A2;  assign a_in_s[3] = A3;
  assign a_in_s[4] = A4;  assign a_in_s[5] = A5;  assign a_in_s[6] = A6;
  assign a_in_s[7] = A7;  assign a_in_s[8] = A8;  assign a_in_s[9] = A9;
  assign a_in_s[10] = A10;

  // A frame arriving with the strobe takes effect for that same sample
  always_comb begin
    if (frame_v) begin
      for (int i = 1; i <= LPC_ORDER; i++) sel_a_s[i] = a_in_s[i];
      sel_voiced_s = voiced;
      sel_fc_s     = freq_count;
      sel_gain_s   = gain;
    end else begin
      for (int i = 1; i <= LPC_ORDER; i++) sel_a_s[i] = st_a_q[i];
      sel_voiced_s = st_voiced_q;
      sel_fc_s     = st_fc_q;
      sel_gain_s   = st_gain_q;
    end
  end

  lpc_excite u_excite (
    .clk      (clk),
    .rst      (rst),
    .step_i   (accept_s),
    .voiced_i (sel_voiced_s),
    .period_i (sel_fc_s),
    .gain_i   (sel_gain_s),
    .e_o      (e_s)
  );

  assign coef_ext_s = {{CW{act_a_q[k_q][CW-1]}}, act_a_q[k_q]};
  assign hist_ext_s = {{DW{hist_q[k_q][DW-1]}}, hist_q[k_q]};
  assign prod_s     = coef_ext_s * hist_ext_s;
  assign sat_s      = sat_dw(acc_q[AW-1:Q_FRAC]);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (v) state_d = ST_EXC; else state_d = ST_IDLE;
      ST_EXC:  state_d = ST_MAC;
      ST_MAC:  if (k_q == 4'd10) state_d = ST_SAT; else state_d = ST_MAC;
      ST_SAT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_s   = 1'b1;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_s   = 1'b0;
        accept_s = v;
      end
      default: busy_s = 1'b1;
    endcase
  end

  // Frame staging, active coefficients, MAC accumulator, history and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= LPC_ORDER; i++) begin
        st_a_q[i]  <= 16'sd0;
        act_a_q[i] <= 16'sd0;
        hist_q[i]  <= 16'sd0;
      end
      st_voiced_q <= 1'b0;
      st_fc_q     <= 16'd0;
      st_gain_q   <= 16'sd0;
      acc_q       <= 36'sd0;
      k_q         <= 4'd1;
      y_q         <= 16'sd0;
      vout_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      vout_q <= 1'b0;
      if (frame_v) begin
        for (int i = 1; i <= LPC_ORDER; i++) st_a_q[i] <= a_in_s[i];
        st_voiced_q <= voiced;
        st_fc_q     <= freq_count;
        st_gain_q   <= gain;
      end
      if (v && busy_s) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            for (int i = 1; i <= LPC_ORDER; i++) act_a_q[i] <= sel_a_s[i];
          end
        end
        ST_EXC: begin
          acc_q <= {{(AW-DW-Q_FRAC){e_s[DW-1]}}, e_s, {Q_FRAC{1'b0}}};
          k_q   <= 4'd1;
        end
        ST_MAC: begin
          acc_q <= acc_q - {{(AW-2*CW){prod_s[2*CW-1]}}, prod_s};
          k_q   <= k_q + 4'd1;
        end
        ST_SAT: begin
          y_q    <= sat_s;
          vout_q <= 1'b1;
          for (int i = LPC_ORDER; i >= 2; i--) hist_q[i] <= hist_q[i-1];
          hist_q[1] <= sat_s;
        end
        default: k_q <= 4'd1;
      endcase
    end
  end

  assign y       = y_q;
  assign vout    = vout_q;
  assign busy    = busy_s;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_lpc_synth.sv
// Self-checking bench for lpc_synth: a behavioural LPC model pushes expected
// samples and their arrival cycle to a queue; each test pops and compares.
module tb_lpc_synth;

  logic clk = 1'b0;
  logic rst, v, frame_v, voiced_in;
  logic signed [15:0] a_in [0:10];
  logic [15:0] fc_in;
  logic signed [15:0] gain_in;
  logic signed [15:0] y;
  logic vout, busy, overrun;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [15:0] y;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  // reference model state
  logic signed [15:0] m_st_a [1:10];
  logic               m_st_voiced;
  int                 m_st_fc;
  logic signed [15:0] m_st_gain;
  longint             m_hist [1:10];
  logic [15:0]        m_lfsr;
  int                 m_cnt;
  logic               m_prev_voiced;

  lpc_synth dut (
    .clk(clk), .rst(rst), .v(v), .frame_v(frame_v),
    .A0(a_in[0]), .A1(a_in[1]), .A2(a_in[2]), .A3(a_in[3]), .A4(a_in[4]),
    .A5(a_in[5]), .A6(a_in[6]), .A7(a_in[7]), .A8(a_in[8]), .A9(a_in[9]),
    .A10(a_in[10]), .voiced(voiced_in), .freq_count(fc_in), .gain(gain_in),
    .y(y), .vout(vout), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    for (int k = 1; k <= 10; k++) begin
      m_st_a[k] = 16'sd0;
      m_hist[k] = 0;
    end
    m_st_voiced   = 1'b0;
    m_st_fc       = 0;
    m_st_gain     = 16'sd0;
    m_lfsr        = 16'hACE1;
    m_cnt         = 0;
    m_prev_voiced = 1'b0;
  endfunction

  function automatic void model_stage();
    for (int k = 1; k <= 10; k++) m_st_a[k] = a_in[k];
    m_st_voiced = voiced_in;
    m_st_fc     = int'(fc_in);
    m_st_gain   = gain_in;
  endfunction

  function automatic logic [15:0] model_sample();
    longint e, acc, t;
    logic fb;
    if (m_st_voiced && !m_prev_voiced) m_cnt = 0;
    m_prev_voiced = m_st_voiced;
    if (m_st_voiced && m_st_fc >= 2) e = (m_cnt == 0) ? longint'(m_st_gain) : 0;
    else e = longint'($signed(m_lfsr)) >>> 3;
    if (m_st_fc < 2) m_cnt = 0;
    else if (m_cnt >= m_st_fc - 1) m_cnt = 0;
    else m_cnt = m_cnt + 1;
    fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
    m_lfsr = {fb, m_lfsr[15:1]};
    acc = e * 4096;
    for (int k = 1; k <= 10; k++) acc = acc - longint'(m_st_a[k]) * m_hist[k];
    t = acc >>> 12;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    for (int k = 10; k >= 2; k--) m_hist[k] = m_hist[k-1];
    m_hist[1] = t;
    return 16'(t);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; v = 1'b0; frame_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  task automatic set_frame(input logic signed [15:0] c1, input logic signed [15:0] c2,
                           input logic signed [15:0] c10, input logic vc,
                           input logic [15:0] fc, input logic signed [15:0] g);
    for (int k = 0; k <= 10; k++) a_in[k] = 16'sd0;
    a_in[0] = 16'sh1000; a_in[1] = c1; a_in[2] = c2; a_in[10] = c10;
    voiced_in = vc; fc_in = fc; gain_in = g;
  endtask

  task automatic pulse_frame();
    @(posedge clk); #1;
    frame_v = 1'b1;
    model_stage();
    @(posedge clk); #1;
    frame_v = 1'b0;
  endtask

  task automatic send_v(input bit with_frame);
    exp_t ex;
    @(posedge clk); #1;
    v = 1'b1;
    if (with_frame) begin
      frame_v = 1'b1;
      model_stage();
    end
    ex.y  = model_sample();
    ex.at = cyc + 13;
    exp_q.push_back(ex);
    @(posedge clk); #1;
    v = 1'b0; frame_v = 1'b0;
  endtask

  task automatic wait_vout(output bit got, output logic [15:0] yv, output int at);
    got = 1'b0; yv = 16'h0; at = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (vout === 1'b1) begin
        got = 1'b1; yv = y; at = cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (y !== 16'h0000) $display("FAIL reset_y: got %0d want 0", y); else n_pass++;
    n_checks++;
    if (vout !== 1'b0) $display("FAIL reset_vout: got %b want 0", vout); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_pulse_train();
    bit got; logic [15:0] yv; int at; exp_t ex;
    set_frame(16'sd0, 16'sd0, 16'sd0, 1'b1, 16'd4, 16'sd1000);
    pulse_frame();
    for (int i = 0; i < 12; i++) begin
      send_v(1'b0);
      if (i == 0) begin
        n_checks++;
        if (busy !== 1'b1) $display("FAIL pulse_busy: got %b want 1", busy); else n_pass++;
      end
      wait_vout(got, yv, at);
      ex = exp_q.pop_front();
      n_checks++;
      if (!got) $display("FAIL pulse[%0d]: no vout, want y=%0d", i, $signed(ex.y));
      else if (yv !== ex.y || at != ex.at)
        $display("FAIL pulse[%0d]: y=%0d cyc=%0d, want y=%0d cyc=%0d", i, $signed(yv), at, $signed(ex.y), ex.at);
      else n_pass++;
      n_checks++;
      if (yv !== ((i % 4 == 0) ? 16'd1000 : 16'd0))
        $display("FAIL pulse_pattern[%0d]: y=%0d want %0d", i, $signed(yv), (i % 4 == 0) ? 1000 : 0);
      else n_pass++;
    end
  endtask

  task automatic test_decay();
    bit got; logic [15:0] yv; int at; exp_t ex;
    do_reset();
    set_frame(16'shF333, 16'sd0, 16'sd0, 1'b1, 16'd100, 16'sd4096);
    pulse_frame();
    for (int i = 0; i < 8; i++) begin
      send_v(1'b0);
      wait_vout(got, yv, at);
      ex = exp_q.pop_front();
      n_checks++;
      if (!got) $display("FAIL decay[%0d]: no vout, want y=%0d", i, $signed(ex.y));
      else if (yv !== ex.y || at != ex.at)
        $display("FAIL decay[%0d]: y=%0d cyc=%0d, want y=%0d cyc=%0d", i, $signed(yv), at, $signed(ex.y), ex.at);
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    bit got; logic [15:0] yv; int at; exp_t ex;
    do_reset();
    set_frame(16'shE000, 16'sd0, 16'sd0, 1'b1, 16'd2, 16'sd32767);
    pulse_frame();
    for (int i = 0; i < 10; i++) begin
      send_v(1'b0);
      wait_vout(got, yv, at);
      ex = exp_q.pop_front();
      n_checks++;
      if (!got) $display("FAIL sat[%0d]: no vout, want y=%0d", i, $signed(ex.y));
      else if (yv !== ex.y || yv !== 16'h7FFF)
        $display("FAIL sat[%0d]: y=%0d, want y=%0d (32767)", i, $signed(yv), $signed(ex.y));
      else n_pass++;
    end
  endtask

  task automatic test_noise();
    bit got; logic [15:0] yv; int at; exp_t ex;
    do_reset();
    set_frame(16'sd0, 16'sd0, 16'sd0, 1'b0, 16'd50, 16'sd1234);
    pulse_frame();
    for (int i = 0; i < 1000; i++) begin
      send_v(1'b0);
      wait_vout(got, yv, at);
      ex = exp_q.pop_front();
      n_checks++;
      if (!got) $display("FAIL noise[%0d]: no vout, want y=%0d", i, $signed(ex.y));
      else if (yv !== ex.y) $display("FAIL noise[%0d]: y=%0d, want y=%0d", i, $signed(yv), $signed(ex.y));
      else n_pass++;
    end
  endtask

  task automatic test_overrun();
    bit got; logic [15:0] yv; int at; exp_t ex;
    do_reset();
    set_frame(16'shF800, 16'sh0400, 16'sh0100, 1'b1, 16'd4, 16'sd500);
    pulse_frame();
    send_v(1'b0);
    wait_vout(got, yv, at);
    ex = exp_q.pop_front();
    n_checks++;
    if (!got || yv !== ex.y) $display("FAIL ovr_pre: y=%0d want %0d", $signed(yv), $signed(ex.y)); else n_pass++;
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else n_pass++;
    send_v(1'b0);
    repeat (3) @(posedge clk);
    #1 v = 1'b1;
    @(posedge clk); #1 v = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun); else n_pass++;
    wait_vout(got, yv, at);
    ex = exp_q.pop_front();
    n_checks++;
    if (!got) $display("FAIL ovr_sample: no vout, want y=%0d", $signed(ex.y));
    else if (yv !== ex.y || at != ex.at)
      $display("FAIL ovr_sample: y=%0d cyc=%0d, want y=%0d cyc=%0d", $signed(yv), at, $signed(ex.y), ex.at);
    else n_pass++;
    repeat (4) @(posedge clk);
    send_v(1'b0);
    wait_vout(got, yv, at);
    ex = exp_q.pop_front();
    n_checks++;
    if (!got || yv !== ex.y) $display("FAIL ovr_next: y=%0d want %0d", $signed(yv), $signed(ex.y)); else n_pass++;
    n_checks++;
    if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else n_pass++;
  endtask

  task automatic test_frame_swap();
    bit got; logic [15:0] yv; int at; exp_t ex;
    do_reset();
    set_frame(16'shF333, 16'sd0, 16'sd0, 1'b1, 16'd3, 16'sd2000);
    pulse_frame();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) set_frame(16'sh0800, 16'shFC00, 16'sh0200, 1'b1, 16'd5, -16'sd1500);
      if (i == 3) begin
        send_v(1'b0);
        repeat (3) @(posedge clk);
        set_frame(16'sd0, 16'sh1000, 16'shFF00, 1'b0, 16'd7, 16'sd3000);
        pulse_frame();
      end else begin
        send_v(i == 2);
      end
      wait_vout(got, yv, at);
      ex = exp_q.pop_front();
      n_checks++;
      if (!got) $display("FAIL swap[%0d]: no vout, want y=%0d", i, $signed(ex.y));
      else if (yv !== ex.y) $display("FAIL swap[%0d]: y=%0d, want y=%0d", i, $signed(yv), $signed(ex.y));
      else n_pass++;
    end
    for (int i = 4; i < 7; i++) begin
      send_v(1'b0);
      wait_vout(got, yv, at);
      ex = exp_q.pop_front();
      n_checks++;
      if (!got) $display("FAIL swap[%0d]: no vout, want y=%0d", i, $signed(ex.y));
      else if (yv !== ex.y) $display("FAIL swap[%0d]: y=%0d, want y=%0d", i, $signed(yv), $signed(ex.y));
      else n_pass++;
    end
  endtask

  task automatic test_rst_mid_mac();
    bit got; logic [15:0] yv; int at; exp_t ex; int seen;
    do_reset();
    set_frame(16'shF333, 16'sh0300, 16'sd0, 1'b1, 16'd6, 16'sd3000);
    pulse_frame();
    for (int i = 0; i < 2; i++) begin
      send_v(1'b0);
      wait_vout(got, yv, at);
      ex = exp_q.pop_front();
      n_checks++;
      if (!got || yv !== ex.y) $display("FAIL rstmid_pre[%0d]: y=%0d want %0d", i, $signed(yv), $signed(ex.y)); else n_pass++;
    end
    send_v(1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vout === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL rstmid_novout: got %0d pulses want 0", seen); else n_pass++;
    n_checks++;
    if (y !== 16'h0000) $display("FAIL rstmid_y: got %0d want 0", $signed(y)); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    set_frame(16'shF333, 16'sh0300, 16'sd0, 1'b1, 16'd6, 16'sd3000);
    pulse_frame();
    for (int i = 0; i < 3; i++) begin
      send_v(1'b0);
      wait_vout(got, yv, at);
      ex = exp_q.pop_front();
      n_checks++;
      if (!got) $display("FAIL rstmid_post[%0d]: no vout, want y=%0d", i, $signed(ex.y));
      else if (yv !== ex.y || at != ex.at)
        $display("FAIL rstmid_post[%0d]: y=%0d cyc=%0d, want y=%0d cyc=%0d", i, $signed(yv), at, $signed(ex.y), ex.at);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; v = 1'b0; frame_v = 1'b0;
    set_frame(16'sd0, 16'sd0, 16'sd0, 1'b0, 16'd0, 16'sd0);
    model_reset();
    test_reset();
    test_pulse_train();
    test_decay();
    test_saturate();
    test_overrun();
    test_frame_swap();
    test_rst_mid_mac();
    test_noise();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
